// File: rtl/sequence_fsm_pkg.sv
// Shared types and constants for the sequence_fsm run detector.
// Holds the detector state encoding, the default run length and
// a helper that sizes the run counter.
package sequence_fsm_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DET  = 2'd2
    } state_t;

    localparam int MIN_ONES_DEFAULT = 2;

    // The counter must be able to hold the threshold value itself,
    // because it saturates there.
    function automatic int run_cnt_width(input int min_ones);
        return $clog2(min_ones + 1);
    endfunction

endpackage

// File: rtl/sequence_run_cnt.sv
// Saturating run counter for the sequence_fsm detector.
// clr has priority over inc. The count sticks at THRESH once it gets there.
// reach is high when the increment on this edge lands on THRESH, or when the
// count is already there. The top uses it to decide on the move into S_DET.
module sequence_run_cnt #(
    parameter int THRESH = 2,
    parameter int WIDTH  = $clog2(THRESH + 1)
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic inc,
    output logic reach
);

    localparam logic [WIDTH-1:0] THRESH_C = WIDTH'(THRESH);
    localparam logic [WIDTH-1:0] PRE_C    = WIDTH'(THRESH - 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear on a 0 sample, otherwise count up to THRESH and hold there.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != THRESH_C)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Count register, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Threshold report: this increment reaches THRESH, or the count is already saturated.
    always_comb begin
        reach = inc && !clr && ((cnt_q == PRE_C) || (cnt_q == THRESH_C));
    end

endmodule

// File: rtl/sequence_fsm.sv
// sequence_fsm: serial detector that flags a run of at least MIN_ONES
// consecutive 1s on data_in.
// Build option SEQUENCE_FSM_MEALY_EN:
//   - Undefined (default): out is the registered decode of S_DET, one clock
//     of latency.
//   - Defined: out is combinational. It goes high in the same cycle as the
//     qualifying 1 and is forced low while rst is high.
// The state transitions are the same in both builds.
module sequence_fsm
    import sequence_fsm_pkg::*;
#(
    parameter int MIN_ONES = MIN_ONES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic data_in,
    output logic out
);

    state_t state_q;
    state_t state_d;
    logic   reach;

    // A 0 sample clears the run. A 1 sample extends it.
    sequence_run_cnt #(
        .THRESH (MIN_ONES),
        .WIDTH  (run_cnt_width(MIN_ONES))
    ) u_cnt (
        .clk   (clk),
        .srst  (rst),
        .clr   (!data_in),
        .inc   (data_in),
        .reach (reach)
    );

    // State register; reset returns to S_IDLE regardless of data_in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a 0 always ends the run. A 1 moves to S_DET once the count
    // reaches MIN_ONES. With MIN_ONES = 1, that happens straight from S_IDLE.
    always_comb begin
        state_d = state_q;
        if (!data_in) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE,
                S_RUN:   state_d = reach ? S_DET : S_RUN;
                S_DET:   state_d = S_DET;
                default: state_d = S_IDLE;
            endcase
        end
    end

`ifdef SEQUENCE_FSM_MEALY_EN
    // Mealy output: high while the current 1 completes or extends a qualifying run.
    always_comb begin
        out = !rst && data_in && ((state_q == S_DET) || reach);
    end
`else
    logic out_d;
    logic out_q;

    // Moore output decode, taken from the next state so the flop lines up with state_q.
    always_comb begin
        out_d = (state_d == S_DET);
    end

    // Output register, so out stays free of decode glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;
`endif

endmodule

// File: tb/tb_sequence_fsm.sv
// Directed testbench for sequence_fsm with MIN_ONES = 2. Expected values are
// worked out by hand from the detector's behaviour. The Moore or Mealy
// expectations are chosen by SEQUENCE_FSM_MEALY_EN.
module tb_sequence_fsm;
    import sequence_fsm_pkg::*;

    logic clk;
    logic rst;
    logic data_in;
    logic out;

    int ntests = 0;
    int nfail  = 0;

    sequence_fsm #(.MIN_ONES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .out     (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Moore step: apply inputs, let one edge sample them, then check the registered out.
    task automatic mo(input logic d, input logic r, input logic exp, input string tag);
        @(negedge clk);
        data_in = d;
        rst     = r;
        @(posedge clk);
        #1;
        chk(tag, {7'd0, out}, {7'd0, exp});
    endtask

    // Mealy step: apply inputs and check the combinational out before the edge samples them.
    task automatic me(input logic d, input logic r, input logic exp, input string tag);
        @(negedge clk);
        data_in = d;
        rst     = r;
        #1;
        chk(tag, {7'd0, out}, {7'd0, exp});
    endtask

    initial begin
        rst     = 1'b1;
        data_in = 1'b1;
`ifndef SEQUENCE_FSM_MEALY_EN
        // Reset held for two cycles with data_in high.
        mo(1, 1, 0, "rst_c0");
        mo(1, 1, 0, "rst_c1");
        chk("rst_state", 8'(dut.state_q), 8'(S_IDLE));
        chk("rst_cnt", 8'(dut.u_cnt.cnt_q), 8'd0);
        // Alternating stream never detects.
        for (int i = 0; i < 4; i++) begin
            mo(1, 0, 0, "alt_one");
            mo(0, 0, 0, "alt_zero");
        end
        // Long zero stream, then 1,0.
        for (int i = 0; i < 6; i++) mo(0, 0, 0, "zeros");
        mo(1, 0, 0, "zeros_one");
        mo(0, 0, 0, "zeros_end");
        // 1,0,1,1,0: out high for exactly one cycle.
        mo(1, 0, 0, "p1011_a");
        mo(0, 0, 0, "p1011_b");
        mo(1, 0, 0, "p1011_c");
        mo(1, 0, 1, "p1011_det");
        mo(0, 0, 0, "p1011_drop");
        mo(0, 0, 0, "p1011_idle");
        // Five 1s then 0: out high for four cycles, count saturates at 2.
        mo(1, 0, 0, "run5_1");
        mo(1, 0, 1, "run5_2");
        mo(1, 0, 1, "run5_3");
        chk("run5_cnt_sat3", 8'(dut.u_cnt.cnt_q), 8'd2);
        mo(1, 0, 1, "run5_4");
        mo(1, 0, 1, "run5_5");
        chk("run5_cnt_sat5", 8'(dut.u_cnt.cnt_q), 8'd2);
        chk("run5_state", 8'(dut.state_q), 8'(S_DET));
        mo(0, 0, 0, "run5_drop");
        chk("run5_cnt_clr", 8'(dut.u_cnt.cnt_q), 8'd0);
        // Reset while in S_DET: the run is discarded.
        mo(1, 0, 0, "rdet_1");
        mo(1, 0, 1, "rdet_2");
        mo(1, 1, 0, "rdet_rst");
        chk("rdet_state", 8'(dut.state_q), 8'(S_IDLE));
        mo(1, 0, 0, "rdet_fresh1");
        mo(1, 0, 1, "rdet_fresh2");
        mo(0, 0, 0, "rdet_end");
`else
        // Reset forces out low even with data_in high.
        me(1, 1, 0, "mrst_c0");
        me(1, 1, 0, "mrst_c1");
        // 0,1,1: out high in the cycle the second 1 is present.
        me(0, 0, 0, "m011_0");
        me(1, 0, 0, "m011_1");
        me(1, 0, 1, "m011_2");
        me(1, 0, 1, "m011_3");
        me(0, 0, 0, "m011_drop");
        // Alternating stream never detects.
        for (int i = 0; i < 4; i++) begin
            me(1, 0, 0, "malt_one");
            me(0, 0, 0, "malt_zero");
        end
        // Reset while in S_DET, then two fresh 1s are needed.
        me(1, 0, 0, "mrdet_1");
        me(1, 0, 1, "mrdet_2");
        me(1, 1, 0, "mrdet_rst");
        me(1, 0, 0, "mrdet_fresh1");
        me(1, 0, 1, "mrdet_fresh2");
        me(0, 0, 0, "mrdet_end");
`endif
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
